// File: rtl/lfsr_noise_source_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_noise_source_if : sample output handshake bundle (valid/ready + pulses)
// Rev 1.0
// ----------------------------------------------------------------------------
interface lfsr_noise_source_if #(
  parameter int NUM_BITS = 16
);
  logic [NUM_BITS-1:0] o_LFSR_Data;
  logic                o_LFSR_Valid;
  logic                i_Ready;
  logic                o_LFSR_Done;
  logic                o_Lockup;

  modport master (
    output o_LFSR_Data,
    output o_LFSR_Valid,
    output o_LFSR_Done,
    output o_Lockup,
    input  i_Ready
  );

  modport slave (
    input  o_LFSR_Data,
    input  o_LFSR_Valid,
    input  o_LFSR_Done,
    input  o_Lockup,
    output i_Ready
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_noise_source.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_noise_source : XNOR LFSR sample generator, STEP shifts/sample, divider,
// valid/ready output. Optional lock-up guard: LFSR_LOCKUP_GUARD_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module lfsr_noise_source #(
  parameter int NUM_BITS = 16,
  parameter int STEP     = 1,
  parameter int DIV_W    = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic [NUM_BITS-1:0] i_Taps,
  input  logic [DIV_W-1:0]    i_Div,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  lfsr_noise_source_if.master src
);

  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

  logic [NUM_BITS-1:0] state_q, state_d;
  logic [NUM_BITS-1:0] seed_q,  seed_d;
  logic [NUM_BITS-1:0] data_q,  data_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic                valid_q, valid_d;
  logic                done_q,  done_d;
  logic [NUM_BITS-1:0] adv_start;
  logic [NUM_BITS-1:0] adv;
  logic                tick;
  logic                accept;
`ifdef LFSR_LOCKUP_GUARD_EN
  logic                lock_q,  lock_d;
`endif

  function automatic logic [NUM_BITS-1:0] f_shift(
    input logic [NUM_BITS-1:0] s,
    input logic [NUM_BITS-1:0] taps
  );
    return {s[NUM_BITS-2:0], ~^(s & taps)};
  endfunction

  assign tick   = i_Enable && (div_q == i_Div);
  assign accept = tick && (!valid_q || src.i_Ready);

  // The all-ones state is the XNOR lock-up point; the guard restarts from zero.
  always_comb begin
    adv_start = state_q;
`ifdef LFSR_LOCKUP_GUARD_EN
    if (state_q == ALL_ONES) begin
      adv_start = '0;
    end
`endif
    adv = adv_start;
    for (int k = 0; k < STEP; k++) begin
      adv = f_shift(adv, i_Taps);
    end
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    data_d  = data_q;
    div_d   = div_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
    lock_d  = 1'b0;
`endif
    if (i_Seed_DV) begin
      state_d = i_Seed_Data;
      seed_d  = i_Seed_Data;
      div_d   = '0;
      valid_d = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
      if (i_Seed_Data == ALL_ONES) begin
        state_d = '0;
        seed_d  = '0;
        lock_d  = 1'b1;
      end
`endif
    end else if (accept) begin
      div_d   = '0;
      state_d = adv;
      data_d  = adv;
      valid_d = 1'b1;
      done_d  = (adv == seed_q);
`ifdef LFSR_LOCKUP_GUARD_EN
      lock_d  = (state_q == ALL_ONES);
`endif
    end else begin
      // A blocked tick leaves the divider parked at i_Div until the sample drains.
      if (i_Enable && !tick) begin
        div_d = div_q + 1'b1;
      end
      if (valid_q && src.i_Ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= '0;
      seed_q  <= '0;
      data_q  <= '0;
      div_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef LFSR_LOCKUP_GUARD_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign src.o_LFSR_Data  = data_q;
  assign src.o_LFSR_Valid = valid_q;
  assign src.o_LFSR_Done  = done_q;
`ifdef LFSR_LOCKUP_GUARD_EN
  assign src.o_Lockup     = lock_q;
`else
  assign src.o_Lockup     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_noise_source.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lfsr_noise_source : two 4-bit instances (STEP=1, STEP=2) checked against
// a sequence-level reference model plus table vectors and corner sequences.
// ----------------------------------------------------------------------------
module tb_lfsr_noise_source;

`ifdef LFSR_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] div;
  logic       sdv;
  logic [3:0] sdata;
  logic [3:0] taps;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_noise_source_if #(.NUM_BITS(4)) if0 ();
  lfsr_noise_source_if #(.NUM_BITS(4)) if1 ();
  assign if0.i_Ready = rdy;
  assign if1.i_Ready = rdy;

  lfsr_noise_source #(.NUM_BITS(4), .STEP(1), .DIV_W(8)) u_dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Taps(taps), .i_Div(div),
    .i_Seed_DV(sdv), .i_Seed_Data(sdata), .src(if0.master)
  );
  lfsr_noise_source #(.NUM_BITS(4), .STEP(2), .DIV_W(8)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Taps(taps), .i_Div(div),
    .i_Seed_DV(sdv), .i_Seed_Data(sdata), .src(if1.master)
  );

  // ---------------- reference model (per instance) ----------------
  int         c_step [2] = '{1, 2};
  logic [3:0] m_st   [2];
  logic [3:0] m_sd   [2];
  int         m_cnt  [2];
  logic       m_valid[2];
  logic [3:0] m_data [2];
  logic       m_done [2];
  logic       m_lock [2];

  // Successor = shift left, new LSB is 1 when the tapped bits have even parity.
  function automatic logic [3:0] succ(input logic [3:0] x, input logic [3:0] t);
    int p;
    p = $countones(x & t);
    return 4'(((int'(x) * 2) % 16) + ((p % 2 == 0) ? 1 : 0));
  endfunction

  task automatic model_step(input int i);
    logic [3:0] s;
    bit         tk;
    m_done[i] = 1'b0;
    m_lock[i] = 1'b0;
    if (sdv) begin
      s = sdata;
      if (GUARD && s == 4'hF) begin
        s = 4'h0;
        m_lock[i] = 1'b1;
      end
      m_st[i] = s; m_sd[i] = s; m_cnt[i] = 0; m_valid[i] = 1'b0;
    end else begin
      tk = en && (m_cnt[i] == int'(div));
      if (tk && (!m_valid[i] || rdy)) begin
        s = m_st[i];
        if (GUARD && s == 4'hF) begin
          s = 4'h0;
          m_lock[i] = 1'b1;
        end
        for (int k = 0; k < c_step[i]; k++) s = succ(s, taps);
        m_st[i] = s; m_data[i] = s; m_valid[i] = 1'b1; m_cnt[i] = 0;
        m_done[i] = (s == m_sd[i]);
      end else begin
        if (en && !tk) m_cnt[i] = (m_cnt[i] + 1) % 256;
        if (m_valid[i] && rdy) m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic model_cmp(input int i, input logic v, input logic [3:0] d,
                           input logic dn, input logic lk);
    tests++;
    if ({v, d, dn, lk} !== {m_valid[i], m_data[i], m_done[i], m_lock[i]}) begin
      fails++;
      $display("FAIL model%0d t=%0t: got v=%b d=%h done=%b lock=%b, required v=%b d=%h done=%b lock=%b",
               i, $time, v, d, dn, lk, m_valid[i], m_data[i], m_done[i], m_lock[i]);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = '0; m_sd[i] = '0; m_cnt[i] = 0; m_valid[i] = 1'b0;
        m_data[i] = '0; m_done[i] = 1'b0; m_lock[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
    #1;
    model_cmp(0, if0.o_LFSR_Valid, if0.o_LFSR_Data, if0.o_LFSR_Done, if0.o_Lockup);
    model_cmp(1, if1.o_LFSR_Valid, if1.o_LFSR_Data, if1.o_LFSR_Done, if1.o_Lockup);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    sdv = 1'b1; sdata = s; taps = t; div = d; en = 1'b1;
    cyc();
    sdv = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!if0.o_LFSR_Valid && n < 40);
  endtask

  typedef struct {
    logic [3:0] taps;
    logic [3:0] seed;
    logic [3:0] e1[4];
    logic [3:0] e2[2];
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ndone;
    bit sawf;
    logic [3:0] g1[4];
    logic [3:0] g2[2];
    int n1, n2;

    vecs[0] = '{taps: 4'hC, seed: 4'h0, e1: '{4'h1, 4'h3, 4'h7, 4'hE}, e2: '{4'h3, 4'hE}};
    vecs[1] = '{taps: 4'hC, seed: 4'hD, e1: '{4'hB, 4'h6, 4'hC, 4'h9}, e2: '{4'h6, 4'h9}};
    vecs[2] = '{taps: 4'h0, seed: 4'h0, e1: '{4'h1, 4'h3, 4'h7, 4'hF}, e2: '{4'h3, 4'hF}};
    vecs[3] = '{taps: 4'h9, seed: 4'h0, e1: '{4'h1, 4'h2, 4'h5, 4'hA}, e2: '{4'h2, 4'hA}};

    rst_n = 1'b0; en = 1'b0; rdy = 1'b0; div = '0; sdv = 1'b0; sdata = '0; taps = 4'hC;
    repeat (3) cyc();
    chk("reset_valid", if0.o_LFSR_Valid, 0);
    chk("reset_data",  if0.o_LFSR_Data, 0);
    chk("reset_done",  if0.o_LFSR_Done, 0);
    chk("reset_lock",  if0.o_Lockup, 0);
    rst_n = 1'b1;

    // Table vectors: first samples of both instances after a seed load.
    foreach (vecs[r]) begin
      rdy = 1'b1;
      load(vecs[r].seed, vecs[r].taps, 8'd0);
      n1 = 0; n2 = 0;
      for (int k = 0; k < 4; k++) begin g1[k] = 'x; end
      for (int k = 0; k < 2; k++) begin g2[k] = 'x; end
      for (int c = 0; c < 12 && n1 < 4; c++) begin
        cyc();
        if (if0.o_LFSR_Valid && n1 < 4) begin g1[n1] = if0.o_LFSR_Data; n1++; end
        if (if1.o_LFSR_Valid && n2 < 2) begin g2[n2] = if1.o_LFSR_Data; n2++; end
      end
      for (int k = 0; k < 4; k++) chk($sformatf("vec%0d_s1_%0d", r, k), g1[k], vecs[r].e1[k]);
      for (int k = 0; k < 2; k++) chk($sformatf("vec%0d_s2_%0d", r, k), g2[k], vecs[r].e2[k]);
    end

    // Full period: Done only on the 15th sample (0x0), 0xF never appears.
    rdy = 1'b1;
    load(4'h0, 4'hC, 8'd0);
    ndone = 0; sawf = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (if0.o_LFSR_Done) ndone++;
      if (if0.o_LFSR_Data == 4'hF) sawf = 1'b1;
      if (k == 15) begin
        chk("period_s15_data", if0.o_LFSR_Data, 4'h0);
        chk("period_s15_done", if0.o_LFSR_Done, 1);
        chk("period_step2_done", if1.o_LFSR_Done, 1);
      end else if (k == 14) begin
        chk("period_step2_nodone", if1.o_LFSR_Done, 0);
      end
    end
    chk("period_done_count", ndone, 1);
    chk("period_no_F", sawf, 0);
    cyc();
    chk("period_repeat", if0.o_LFSR_Data, 4'h1);

    // Backpressure: sample 0x1 held, then 0x3, 0x7 without skips.
    load(4'h0, 4'hC, 8'd0);
    cyc();
    chk("bp_first", if0.o_LFSR_Data, 4'h1);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_hold", {if0.o_LFSR_Valid, if0.o_LFSR_Data}, {1'b1, 4'h1});
    end
    rdy = 1'b1;
    cyc();
    chk("bp_next1", if0.o_LFSR_Data, 4'h3);
    cyc();
    chk("bp_next2", if0.o_LFSR_Data, 4'h7);

    // Divider and enable freeze.
    load(4'h0, 4'hC, 8'd3);
    wait_valid(n);
    chk("div_first_gap", n, 4);
    wait_valid(n);
    chk("div_gap", n, 4);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk("en_frozen_valid", if0.o_LFSR_Valid, 0);
    en = 1'b1;
    wait_valid(n);
    chk("en_resume_gap", n, 3);
    chk("en_resume_data", if0.o_LFSR_Data, 4'h7);

    // Seed load collides with a pending sample and a pending tick.
    load(4'h0, 4'hC, 8'd0);
    cyc();
    rdy = 1'b0;
    cyc();
    chk("col_pending", if0.o_LFSR_Valid, 1);
    sdv = 1'b1; sdata = 4'h5;
    cyc();
    sdv = 1'b0;
    chk("col_valid_done", {if0.o_LFSR_Valid, if0.o_LFSR_Done}, 2'b00);
    rdy = 1'b1;
    cyc();
    chk("col_first", {if0.o_LFSR_Valid, if0.o_LFSR_Data}, {1'b1, 4'hA});

    // Lock-up seed.
    load(4'hF, 4'hC, 8'd0);
`ifdef LFSR_LOCKUP_GUARD_EN
    chk("lock_pulse", if0.o_Lockup, 1);
    cyc();
    chk("lock_pulse_end", if0.o_Lockup, 0);
    chk("lock_first", if0.o_LFSR_Data, 4'h1);
    chk("lock_first_s2", if1.o_LFSR_Data, 4'h3);
`else
    chk("lock_none", if0.o_Lockup, 0);
    cyc();
    chk("lock_stuck1", if0.o_LFSR_Data, 4'hF);
    cyc();
    chk("lock_stuck2", {if0.o_LFSR_Data, if0.o_Lockup}, {4'hF, 1'b0});
`endif

    // Asynchronous reset mid-run, then restart from state 0.
    load(4'h3, 4'hC, 8'd0);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {if0.o_LFSR_Valid, if0.o_LFSR_Data, if0.o_LFSR_Done, if0.o_Lockup}, 7'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_restart", {if0.o_LFSR_Valid, if0.o_LFSR_Data}, {1'b1, 4'h1});

    // Randomized run; the reference model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) div = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: taps = 4'hC;
          1: taps = 4'h9;
          2: taps = 4'h0;
          default: taps = 4'($urandom);
        endcase
      end
      sdv = ($urandom_range(0, 39) == 0);
      sdata = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    end
    sdv = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_noise_source.md
# lfsr_noise_source

- Parametrised pseudo-random sample generator for the data_source path of the lock-in design.
- XNOR-feedback LFSR with a runtime-programmable tap mask, STEP shifts per sample, and a programmable sample-rate divider.
- Output uses a valid/ready handshake, with backpressure that stalls generation without skipping any sequence value.
- Provides a period-complete pulse and an optional lock-up guard.

## Interface
- NUM_BITS, 16, LFSR width; legal 3..64.
- STEP, 1, LFSR shifts per produced sample; legal 1..NUM_BITS.
- DIV_W, 8, width of the divider control.
- i_Clk  in  1  single clock, rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Enable  in  1  run enable; low freezes divider and LFSR state.
- i_Taps  in  NUM_BITS  tap mask; bit k-1 set puts position k in the feedback (position NUM_BITS is the MSB).
- i_Div  in  DIV_W  one sample every i_Div+1 enabled cycles.
- i_Seed_DV  in  1  seed load strobe.
- i_Seed_Data  in  NUM_BITS  seed value.
- o_LFSR_Data  out  NUM_BITS  sample, held while o_LFSR_Valid=1.
- o_LFSR_Valid  out  1  sample available.
- i_Ready  in  1  consumer accepts the sample when Valid&Ready.
- o_LFSR_Done  out  1  one-cycle pulse when the advanced state equals the latched seed.
- o_Lockup  out  1  one-cycle pulse when the lock-up guard acts.

## Operation
- **Single shift:** fb = ~^(state & i_Taps), i.e. inverted parity; next = {state[NUM_BITS-2:0], fb}. One sample advance applies STEP single shifts combinationally, unrolled.
- **Reset:** state=0, r_Seed=0, divider=0, o_LFSR_Data=0, o_LFSR_Valid=0, o_LFSR_Done=0, o_Lockup=0.
- **Seed load:** when i_Seed_DV=1, regardless of i_Enable:
  - state and r_Seed take i_Seed_Data; divider clears; o_LFSR_Valid clears.
  - Seed load has priority over tick, Ready, and taps.
- **Divider:** counts enabled cycles 0..i_Div. A tick occurs when divider==i_Div and i_Enable=1. The divider wraps to 0 only when the tick is accepted.
- **Tick accepted** when o_LFSR_Valid=0 or i_Ready=1:
  - state advances STEP shifts.
  - o_LFSR_Data takes the new state; o_LFSR_Valid=1.
  - o_LFSR_Done=1 if the new state equals r_Seed.
- **Tick blocked** when Valid=1 and Ready=0: divider holds at i_Div and state holds. No sample is dropped or skipped.
- **Handshake without tick:** Valid&Ready clears o_LFSR_Valid.
- **Taps or i_Div change mid-run:** takes effect at the next advance or compare.
- **Zero tap mask:** fb is constant 1.
- **Period:** seed returns after P/gcd(P,STEP) ticks, where P is the sequence period (2^NUM_BITS−1 for maximal taps). Done is compared only at sample boundaries.

## Timing
- Sample appears on o_LFSR_Data/o_LFSR_Valid the cycle after the accepted tick.
- o_LFSR_Done is aligned with the same sample.
- Max throughput is one sample per clock (i_Div=0, i_Ready held 1).
- Seed load: Valid=0 the next cycle; the first sample is the seed advanced once, i_Div+1 enabled cycles later.
- i_Enable low: no tick; a pending sample stays valid until consumed.
- Reset asserted mid-operation clears everything immediately; generation restarts from state 0 after release.

## Configuration
- **LFSR_LOCKUP_GUARD_EN defined:**
  - A seed of all-ones loads 0 instead, and r_Seed also takes 0.
  - If state is all-ones at an accepted tick, the advance starts from 0 instead.
  - Either event pulses o_Lockup for one cycle.
- **LFSR_LOCKUP_GUARD_EN undefined:** values are used as-is; o_Lockup is tied 0; an all-ones state with an even tap count locks permanently.

## Test plan
- **Basic sequence:** NUM_BITS=4, STEP=1, i_Taps=4'b1100, seed 0, i_Div=0, i_Ready=1 -> samples 0x1, 0x3, 0x7, 0xE, 0xD, ... One Done pulse on the 15th sample (0x0), then repeats with period 15; 0xF is never produced.
- **Backpressure:** same setup, i_Ready=0 for 5 cycles after the first sample -> o_LFSR_Data stays 0x1 with Valid=1. After release, the next samples are 0x3, 0x7 with no skips.
- **Divider and enable:** i_Div=3 -> Valid rises every 4 cycles. i_Enable low 10 cycles mid-count -> divider freezes, resumes with the remaining count.
- **STEP>1:** NUM_BITS=4, STEP=2 -> samples 0x3, 0xE, ... (every second value). Done after 15 ticks.
- **Seed load collision:** i_Seed_DV=1 with Valid=1, Ready=0 and a pending tick -> state=seed, Valid=0, no Done. First sample is the seed's successor.
- **Lock-up guard:** seed 0xF with LFSR_LOCKUP_GUARD_EN -> o_Lockup pulse, first sample 0x1. Without the macro -> samples stay 0xF, o_Lockup=0.
